// File: rtl/fp_pkg.sv
// fp_pkg: shared exponent width and alignment FSM state encoding.
package fp_pkg;
    localparam int EXP_W = 5;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        ADD   = 2'd2
    } state_t;
endpackage

// File: rtl/fp_align_add_if.sv
// fp_align_add_if: operand request and result bundle for the alignment/add stage.
interface fp_align_add_if
    import fp_pkg::*;
#(
    parameter int SIZE = 10
);
    logic             start;
    logic             signA;
    logic             signB;
    logic [SIZE-2:0]  mantA;
    logic [SIZE-2:0]  mantB;
    logic [EXP_W-1:0] expA;
    logic [EXP_W-1:0] expB;
    logic             busy;
    logic             done;
    logic             sumSign;
    logic [SIZE-1:0]  sumMant;
    logic [EXP_W-1:0] sumExp;
    logic             zero;

    modport master (
        output start, signA, signB, mantA, mantB, expA, expB,
        input  busy, done, sumSign, sumMant, sumExp, zero
    );

    modport slave (
        input  start, signA, signB, mantA, mantB, expA, expB,
        output busy, done, sumSign, sumMant, sumExp, zero
    );
endinterface

// File: rtl/fp_align_add_mant_addsub.sv
// mant_addsub: combinational magnitude add/subtract with carry headroom bit.
module mant_addsub #(
    parameter int SIZE = 10
) (
    input  logic [SIZE-2:0] a,
    input  logic [SIZE-2:0] b,
    input  logic            sub,
    output logic [SIZE-1:0] mag,
    output logic            a_ge,
    output logic            zero
);
    always_comb begin
        a_ge = a >= b;
        mag  = sub ? (a_ge ? {1'b0, a} - {1'b0, b} : {1'b0, b} - {1'b0, a}) : {1'b0, a} + {1'b0, b};
        zero = mag == '0;
    end
endmodule

// File: rtl/fp_align_add.sv
// fp_align_add: sequential exponent alignment (one bit per clock) then magnitude add/subtract.
module fp_align_add
    import fp_pkg::*;
#(
    parameter int SIZE = 10
) (
    input  logic           clkAdd,
    input  logic           reset,
    fp_align_add_if.slave  bus
);
    localparam logic [EXP_W-1:0] SAT = EXP_W'(SIZE - 1);

    state_t           state, nxt;
    logic             sgn_big, sgn_small, sub;
    logic [SIZE-2:0]  m_big, m_small;
    logic [EXP_W-1:0] e_big, cnt, diff;
    logic             swap, a_ge, z;
    logic [SIZE-1:0]  mag;

    mant_addsub #(.SIZE(SIZE)) u_addsub (
        .a    (m_big),
        .b    (m_small),
        .sub  (sub),
        .mag  (mag),
        .a_ge (a_ge),
        .zero (z)
    );

    always_comb begin
        swap = bus.expB > bus.expA;
        diff = swap ? bus.expB - bus.expA : bus.expA - bus.expB;
        sub  = sgn_big != sgn_small;
        nxt  = state == IDLE  ? (bus.start ? ((diff == '0 || diff >= SAT) ? ADD : ALIGN) : IDLE)
             : state == ALIGN ? (cnt == EXP_W'(1) ? ADD : ALIGN)
             : IDLE;
    end

    always_ff @(posedge clkAdd or posedge reset)
        if (reset) state <= IDLE;
        else       state <= nxt;

    always_ff @(posedge clkAdd or posedge reset) begin
        if (reset) begin
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.sumSign <= 1'b0;
            bus.sumMant <= '0;
            bus.sumExp  <= '0;
            bus.zero    <= 1'b0;
            sgn_big     <= 1'b0;
            sgn_small   <= 1'b0;
            m_big       <= '0;
            m_small     <= '0;
            e_big       <= '0;
            cnt         <= '0;
        end else begin
            bus.busy <= nxt != IDLE;
            bus.done <= state == ADD;
            if (state == IDLE && bus.start) begin
                sgn_big   <= swap ? bus.signB : bus.signA;
                sgn_small <= swap ? bus.signA : bus.signB;
                m_big     <= swap ? bus.mantB : bus.mantA;
                // a shift of SIZE-1 or more would clear every bit anyway
                m_small   <= diff >= SAT ? '0 : (swap ? bus.mantA : bus.mantB);
                e_big     <= swap ? bus.expB : bus.expA;
                cnt       <= diff;
            end else if (state == ALIGN) begin
                m_small <= m_small >> 1;
                cnt     <= cnt - 1'b1;
            end else if (state == ADD) begin
                bus.sumMant <= mag;
                bus.zero    <= z;
                bus.sumSign <= z ? 1'b0 : (sub && !a_ge ? sgn_small : sgn_big);
                bus.sumExp  <= z ? '0 : e_big;
            end
        end
    end
endmodule

// File: tb/tb_fp_align_add.sv
// tb_fp_align_add: directed scenario tests for the alignment/add stage.
module tb_fp_align_add;
    logic clkAdd = 1'b0;
    logic reset  = 1'b1;
    int   compared = 0;
    int   mismatched = 0;

    fp_align_add_if #(.SIZE(10)) bus ();

    fp_align_add #(.SIZE(10)) dut (
        .clkAdd (clkAdd),
        .reset  (reset),
        .bus    (bus.slave)
    );

    always #5 clkAdd = ~clkAdd;

    function automatic logic [16:0] res();
        return {bus.sumSign, bus.sumMant, bus.sumExp, bus.zero};
    endfunction

    task automatic launch(input logic sa, input logic [8:0] ma, input logic [4:0] ea,
                          input logic sb, input logic [8:0] mb, input logic [4:0] eb);
        @(negedge clkAdd);
        bus.signA = sa; bus.mantA = ma; bus.expA = ea;
        bus.signB = sb; bus.mantB = mb; bus.expB = eb;
        bus.start = 1'b1;
        @(posedge clkAdd);
        @(negedge clkAdd);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (lat < 20) begin
            if (bus.busy) bc++;
            @(posedge clkAdd);
            lat++;
            @(negedge clkAdd);
            if (bus.done) break;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.signA = 1'b0; bus.mantA = '0; bus.expA = '0;
        bus.signB = 1'b0; bus.mantB = '0; bus.expB = '0;
        reset = 1'b1;
        repeat (2) @(negedge clkAdd);
        compared++;
        if ({bus.busy, bus.done, res()} !== 19'd0) begin
            mismatched++;
            $display("FAIL reset_state: got %h want 0", {bus.busy, bus.done, res()});
        end
        reset = 1'b0;
    endtask

    task automatic test_equal_exp();
        int lat, bc;
        launch(1'b0, 9'h100, 5'd10, 1'b0, 9'h100, 5'd10);
        wait_done(lat, bc);
        compared++;
        if (res() !== {1'b0, 10'h200, 5'd10, 1'b0}) begin
            mismatched++;
            $display("FAIL equal_exp_result: got %h want %h", res(), {1'b0, 10'h200, 5'd10, 1'b0});
        end
        compared++;
        if (lat !== 1) begin
            mismatched++;
            $display("FAIL equal_exp_latency: got %0d want 1", lat);
        end
        @(negedge clkAdd);
        compared++;
        if ({bus.done, res()} !== {1'b0, 1'b0, 10'h200, 5'd10, 1'b0}) begin
            mismatched++;
            $display("FAIL done_pulse_hold: got %h want %h", {bus.done, res()}, {1'b0, 1'b0, 10'h200, 5'd10, 1'b0});
        end
    endtask

    task automatic test_align();
        int lat, bc;
        launch(1'b0, 9'h180, 5'd12, 1'b0, 9'h100, 5'd10);
        wait_done(lat, bc);
        compared++;
        if (res() !== {1'b0, 10'h1C0, 5'd12, 1'b0}) begin
            mismatched++;
            $display("FAIL align_result: got %h want %h", res(), {1'b0, 10'h1C0, 5'd12, 1'b0});
        end
        compared++;
        if (lat !== 3) begin
            mismatched++;
            $display("FAIL align_latency: got %0d want 3", lat);
        end
        compared++;
        if ({bc, bus.busy} !== {32'd3, 1'b0}) begin
            mismatched++;
            $display("FAIL align_busy: got cycles %0d busy_at_done %b want 3 / 0", bc, bus.busy);
        end
    endtask

    task automatic test_cancel_zero();
        int lat, bc;
        launch(1'b0, 9'h1FF, 5'd5, 1'b1, 9'h1FF, 5'd5);
        wait_done(lat, bc);
        compared++;
        if (res() !== {1'b0, 10'h000, 5'd0, 1'b1}) begin
            mismatched++;
            $display("FAIL cancel_zero_result: got %h want %h", res(), {1'b0, 10'h000, 5'd0, 1'b1});
        end
        compared++;
        if (lat !== 1) begin
            mismatched++;
            $display("FAIL cancel_zero_latency: got %0d want 1", lat);
        end
    endtask

    task automatic test_saturate();
        int lat, bc;
        launch(1'b1, 9'h100, 5'd3, 1'b0, 9'h180, 5'd20);
        wait_done(lat, bc);
        compared++;
        if (res() !== {1'b0, 10'h180, 5'd20, 1'b0}) begin
            mismatched++;
            $display("FAIL saturate_result: got %h want %h", res(), {1'b0, 10'h180, 5'd20, 1'b0});
        end
        compared++;
        if (lat !== 1) begin
            mismatched++;
            $display("FAIL saturate_latency: got %0d want 1", lat);
        end
    endtask

    task automatic test_sub_neg();
        int lat, bc;
        launch(1'b0, 9'h100, 5'd8, 1'b1, 9'h180, 5'd8);
        wait_done(lat, bc);
        compared++;
        if (res() !== {1'b1, 10'h080, 5'd8, 1'b0}) begin
            mismatched++;
            $display("FAIL sub_neg_result: got %h want %h", res(), {1'b1, 10'h080, 5'd8, 1'b0});
        end
        compared++;
        if (lat !== 1) begin
            mismatched++;
            $display("FAIL sub_neg_latency: got %0d want 1", lat);
        end
    endtask

    task automatic test_ignore_start();
        int lat, bc;
        launch(1'b0, 9'h180, 5'd12, 1'b0, 9'h100, 5'd10);
        bus.signA = 1'b1; bus.mantA = 9'h1FF; bus.expA = 5'd3;
        bus.signB = 1'b0; bus.mantB = 9'h100; bus.expB = 5'd30;
        bus.start = 1'b1;
        @(posedge clkAdd);
        @(negedge clkAdd);
        bus.start = 1'b0;
        wait_done(lat, bc);
        compared++;
        if (res() !== {1'b0, 10'h1C0, 5'd12, 1'b0}) begin
            mismatched++;
            $display("FAIL ignore_start_result: got %h want %h", res(), {1'b0, 10'h1C0, 5'd12, 1'b0});
        end
        compared++;
        if (lat !== 2) begin
            mismatched++;
            $display("FAIL ignore_start_latency: got %0d want 2", lat);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bc, seen;
        launch(1'b0, 9'h100, 5'd15, 1'b0, 9'h100, 5'd10);
        @(posedge clkAdd);
        @(negedge clkAdd);
        #1 reset = 1'b1;
        #1;
        compared++;
        if ({bus.busy, bus.done, res()} !== 19'd0) begin
            mismatched++;
            $display("FAIL reset_abort_clear: got %h want 0", {bus.busy, bus.done, res()});
        end
        @(negedge clkAdd);
        reset = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clkAdd);
            if (bus.done || bus.busy) seen++;
        end
        compared++;
        if (seen !== 0) begin
            mismatched++;
            $display("FAIL reset_abort_no_done: got %0d active cycles want 0", seen);
        end
        launch(1'b0, 9'h100, 5'd10, 1'b0, 9'h100, 5'd10);
        wait_done(lat, bc);
        compared++;
        if (res() !== {1'b0, 10'h200, 5'd10, 1'b0}) begin
            mismatched++;
            $display("FAIL after_reset_result: got %h want %h", res(), {1'b0, 10'h200, 5'd10, 1'b0});
        end
        compared++;
        if (lat !== 1) begin
            mismatched++;
            $display("FAIL after_reset_latency: got %0d want 1", lat);
        end
    endtask

    initial begin
        test_reset();
        test_equal_exp();
        test_align();
        test_cancel_zero();
        test_saturate();
        test_sub_neg();
        test_ignore_start();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
